// File: rtl/tx_char_replace_if.sv
// Word-level port bundle between the ILA generator side and the 8b/10b encoder side
// of the transmit lane character replacement stage.
interface tx_char_replace_if;
    logic        en_i;
    logic        scr_i;
    logic [3:0]  fe_i;
    logic [3:0]  me_i;
    logic [3:0]  ki_i;
    logic [31:0] di_i;
    logic [31:0] do_o;
    logic [3:0]  ko_o;
    logic [3:0]  fe_out_o;
    logic [3:0]  me_out_o;

    modport slave (
        input  en_i, scr_i, fe_i, me_i, ki_i, di_i,
        output do_o, ko_o, fe_out_o, me_out_o
    );

    modport master (
        output en_i, scr_i, fe_i, me_i, ki_i, di_i,
        input  do_o, ko_o, fe_out_o, me_out_o
    );
endinterface

// File: rtl/tx_char_replace.sv
// JESD204B data-phase /F/ and /A/ substitution on a 4-octet word, octet 0 first in time.
// One register stage; the frame-end history chain across the word is resolved combinationally.
module tx_char_replace (
    input  logic               clk,
    input  logic               rst,
    tx_char_replace_if.slave   bus
);
    localparam logic [7:0] K_F = 8'hFC;
    localparam logic [7:0] K_A = 8'h7C;

    logic [31:0] do_q, do_d;
    logic [3:0]  ko_q, ko_d;
    logic [3:0]  fe_out_q;
    logic [3:0]  me_out_q;
    logic [7:0]  prev_oct_q, prev_oct_d;
    logic        prev_ctl_q, prev_ctl_d;
    logic        hist_vld_q, hist_vld_d;

    logic [7:0]  cur_oct;
    logic        cur_rep;
    logic        cur_ctl;

    // prev_*_d and hist_vld_d ripple through the word so that each frame end sees
    // the nearest earlier one, whether it sits in this word or a previous one.
    always_comb begin
        do_d       = bus.di_i;
        ko_d       = bus.ki_i;
        prev_oct_d = prev_oct_q;
        prev_ctl_d = prev_ctl_q;
        hist_vld_d = hist_vld_q;
        cur_oct    = 8'h00;
        cur_rep    = 1'b0;
        cur_ctl    = 1'b0;

        if (!bus.en_i) begin
            prev_oct_d = 8'h00;
            prev_ctl_d = 1'b0;
            hist_vld_d = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (bus.fe_i[i]) begin
                    cur_oct = bus.di_i[8*i +: 8];
                    cur_rep = 1'b0;
                    if (bus.ki_i[i]) begin
                        cur_ctl = 1'b1;
                    end else begin
                        if (bus.scr_i) begin
                            cur_rep = bus.me_i[i] ? (cur_oct == K_A) : (cur_oct == K_F);
                        end else begin
                            cur_rep = hist_vld_d && (cur_oct == prev_oct_d) &&
                                      (bus.me_i[i] || !prev_ctl_d);
                        end
                        if (cur_rep) begin
                            do_d[8*i +: 8] = bus.me_i[i] ? K_A : K_F;
                            ko_d[i]        = 1'b1;
                        end
                        cur_ctl = cur_rep;
                    end
                    prev_oct_d = cur_oct;
                    prev_ctl_d = cur_ctl;
                    hist_vld_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            do_q       <= 32'h0;
            ko_q       <= 4'h0;
            fe_out_q   <= 4'h0;
            me_out_q   <= 4'h0;
            prev_oct_q <= 8'h00;
            prev_ctl_q <= 1'b0;
            hist_vld_q <= 1'b0;
        end else begin
            do_q       <= do_d;
            ko_q       <= ko_d;
            fe_out_q   <= bus.fe_i;
            me_out_q   <= bus.me_i;
            prev_oct_q <= prev_oct_d;
            prev_ctl_q <= prev_ctl_d;
            hist_vld_q <= hist_vld_d;
        end
    end

    assign bus.do_o     = do_q;
    assign bus.ko_o     = ko_q;
    assign bus.fe_out_o = fe_out_q;
    assign bus.me_out_o = me_out_q;
endmodule
